// File: rtl/lpc_record_scheduler.sv
// Purpose : buffers decoded LPC records and streams each one to the host link as a fixed-order byte sequence.
// Latency : record strobed at edge N into an empty FIFO with the sender idle -> tx_valid with header after edge N+2.
// Backpr. : tx_byte/tx_valid held while tx_ready=0; FIFO fills, then further strobes are dropped and counted.
//
// Ports:
//   lpc_clock, lpc_reset           sole clock, synchronous active-low reset
//   in_cyctype_dir/addr/data/size  decoded record fields, captured when in_clock_enable=1
//   tx_byte, tx_valid, tx_ready    byte stream to the transmitter (valid/ready)
//   ovf_clear                      one-cycle pulse clearing overflow and drop_count
//   overflow, drop_count           sticky drop flag and saturating drop counter
//   fifo_level                     records currently buffered (0..2^DEPTH_LOG2)
//
// Optional build macro LPC_SCHED_SEQNUM_EN: adds an 8-bit per-strobe sequence number, sent as an
// extra first byte of each record (10 bytes per record instead of 9).

module lpc_record_scheduler #(
  parameter int DEPTH_LOG2 = 3,
  parameter int DROP_W     = 8
) (
  input  logic                  lpc_clock,
  input  logic                  lpc_reset,
  input  logic [3:0]            in_cyctype_dir,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           in_data,
  input  logic [3:0]            in_data_size,
  input  logic                  in_clock_enable,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic                  ovf_clear,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_count,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef LPC_SCHED_SEQNUM_EN
  localparam int REC_W = 80;
  localparam int NB    = 10;
`else
  localparam int REC_W = 72;
  localparam int NB    = 9;
`endif
  localparam logic [3:0]          LAST_IDX = 4'(NB - 1);
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DROP_W-1:0]   DC_ONE   = DROP_W'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  logic [3:0]            idx;
  logic [REC_W-1:0]      sr;
  logic [REC_W-1:0]      mem [0:DEPTH-1];
  logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic [REC_W-1:0]      rec_in, head;
  logic                  full, empty, push, pop, drop;

`ifdef LPC_SCHED_SEQNUM_EN
  logic [7:0] seq;
  assign rec_in = {seq, in_cyctype_dir, in_data_size, in_addr, in_data};
`else
  assign rec_in = {in_cyctype_dir, in_data_size, in_addr, in_data};
`endif

  assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // Pop when idle, or when the last byte of the current record is accepted (back-to-back).
  assign pop  = !empty && ((state == IDLE) ||
                (state == SEND && tx_valid && tx_ready && idx == LAST_IDX));
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push = in_clock_enable && (!full || pop);
  assign drop = in_clock_enable && full && !pop;

  always_ff @(posedge lpc_clock) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= rec_in;
  end

  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
`ifdef LPC_SCHED_SEQNUM_EN
      seq        <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + PTR_ONE;
        2'b01:   fifo_level <= fifo_level - PTR_ONE;
        default: fifo_level <= fifo_level;
      endcase
      // Clear wins over the old value, but a drop on the same edge is still recorded.
      if (ovf_clear) begin
        overflow   <= drop;
        drop_count <= drop ? DC_ONE : '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + DC_ONE;
      end
`ifdef LPC_SCHED_SEQNUM_EN
      if (in_clock_enable) seq <= seq + 8'd1;
`endif
    end
  end

  // Sender: sr holds the current record with the byte on the link at the top.
  // The first SEND cycle after IDLE primes tx_byte from sr; later records load straight into tx_byte.
  always_ff @(posedge lpc_clock) begin
    if (!lpc_reset) begin
      state    <= IDLE;
      idx      <= '0;
      sr       <= '0;
      tx_valid <= 1'b0;
      tx_byte  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            sr    <= head;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_byte  <= sr[REC_W-1 -: 8];
          end else if (tx_ready) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (!empty) begin
                sr      <= head;
                tx_byte <= head[REC_W-1 -: 8];
              end else begin
                state    <= IDLE;
                tx_valid <= 1'b0;
                tx_byte  <= '0;
              end
            end else begin
              sr      <= sr << 8;
              idx     <= idx + 4'd1;
              tx_byte <= sr[REC_W-9 -: 8];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_record_scheduler.sv
module tb_lpc_record_scheduler;

  localparam int DEPTH = 8;
  localparam int DCMAX = 255;
`ifdef LPC_SCHED_SEQNUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic        lpc_clock = 1'b0;
  logic        lpc_reset = 1'b0;
  logic [3:0]  in_cyctype_dir = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_data_size = '0;
  logic        in_clock_enable = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        ovf_clear = 1'b0;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [3:0]  fifo_level;

  always #5 lpc_clock = ~lpc_clock;

  lpc_record_scheduler #(.DEPTH_LOG2(3), .DROP_W(8)) dut (
    .lpc_clock(lpc_clock), .lpc_reset(lpc_reset),
    .in_cyctype_dir(in_cyctype_dir), .in_addr(in_addr), .in_data(in_data),
    .in_data_size(in_data_size), .in_clock_enable(in_clock_enable),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ovf_clear(ovf_clear), .overflow(overflow), .drop_count(drop_count),
    .fifo_level(fifo_level)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: records waiting, sender busy/primed, bytes left in current record.
  logic [7:0] exp_q[$];
  int   m_cnt = 0;
  bit   m_busy = 0, m_primed = 0;
  int   m_rem = 0;
  bit   m_ovf = 0;
  int   m_dc = 0;
  logic [7:0] m_seq = '0;

  always @(posedge lpc_clock) begin : model
    bit hs, last, pop, drop, acc;
    if (!lpc_reset) begin
      m_cnt = 0; m_busy = 0; m_primed = 0; m_rem = 0;
      m_ovf = 0; m_dc = 0; m_seq = '0;
      exp_q.delete();
    end else begin
      hs   = m_busy && m_primed && tx_ready;
      last = hs && (m_rem == 1);
      pop  = (m_cnt > 0) && (!m_busy || last);
      drop = in_clock_enable && (m_cnt == DEPTH) && !pop;
      acc  = in_clock_enable && !drop;
      m_cnt = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
      if (acc) begin
`ifdef LPC_SCHED_SEQNUM_EN
        exp_q.push_back(m_seq);
`endif
        exp_q.push_back({in_cyctype_dir, in_data_size});
        for (int k = 3; k >= 0; k--) exp_q.push_back(in_addr[8*k +: 8]);
        for (int k = 3; k >= 0; k--) exp_q.push_back(in_data[8*k +: 8]);
      end
      if (!m_busy) begin
        if (pop) begin m_busy = 1; m_primed = 0; m_rem = NB; end
      end else if (!m_primed) begin
        m_primed = 1;
      end else if (hs) begin
        if (last) begin
          if (pop) m_rem = NB;
          else m_busy = 0;
        end else begin
          m_rem = m_rem - 1;
        end
      end
      if (ovf_clear) begin
        m_ovf = drop;
        m_dc  = drop ? 1 : 0;
      end else if (drop) begin
        m_ovf = 1;
        if (m_dc < DCMAX) m_dc = m_dc + 1;
      end
      if (in_clock_enable) m_seq = m_seq + 8'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares after-edge state and consumes bytes on each handshake.
  bit         held_vld = 0;
  logic [7:0] held_byte = '0;
  always begin : monitor
    @(negedge lpc_clock);
    #2;
    if (chk_en) begin
      check("tx_valid", 32'(tx_valid), 32'(m_busy && m_primed));
      check("fifo_level", 32'(fifo_level), 32'(m_cnt));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_count", 32'(drop_count), 32'(m_dc));
      if (held_vld) check("tx_byte_hold", 32'(tx_byte), 32'(held_byte));
      held_vld  = tx_valid && !tx_ready && lpc_reset;
      held_byte = tx_byte;
      if (tx_valid && tx_ready && lpc_reset) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_byte at %0t: got %0h expected none", $time, tx_byte);
        end else begin
          check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic cyc(input bit stb, input logic [3:0] ct, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] sz,
                     input bit rdy, input bit clr, input bit rst_n);
    @(negedge lpc_clock);
    in_clock_enable = stb;
    in_cyctype_dir  = ct;
    in_addr         = a;
    in_data         = d;
    in_data_size    = sz;
    tx_ready        = rdy;
    ovf_clear       = clr;
    lpc_reset       = rst_n;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, rdy, 1'b0, 1'b1);
  endtask

  task automatic rnd_strobe(input bit rdy, input bit clr);
    cyc(1'b1, 4'($urandom), $urandom, $urandom, 4'($urandom), rdy, clr, 1'b1);
  endtask

  task automatic drain();
    int budget = 600;
    while (budget > 0 && (exp_q.size() != 0 || tx_valid || m_cnt != 0)) begin
      idle(1'b1, 1);
      budget--;
    end
    if (budget == 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
    end
    idle(1'b1, 2);
  endtask

  initial begin
    // Reset
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 2);

    // Single I/O read: 01 00 00 7F E5 00 00 00 6C
    cyc(1'b1, 4'h0, 32'h0000_7fe5, 32'h0000_006c, 4'h1, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 14);

    // Backpressure: ready 1,0,0 repeating
    cyc(1'b1, 4'h0, 32'h0000_7fe5, 32'h0000_006c, 4'h1, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 36; i++) idle((i % 3) == 0, 1);
    drain();

    // Overflow: 10 strobes with ready low
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 4'h2, 32'(i), 32'hA5A5_0000 + 32'(i), 4'h1, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 3);
    // Drop and clear on the same edge
    rnd_strobe(1'b0, 1'b1);
    idle(1'b0, 1);
    drain();
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Drop counter saturation
    for (int i = 0; i < 270; i++) rnd_strobe(1'b0, 1'b0);
    idle(1'b0, 2);
    drain();
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);

    // Back-to-back: 3 consecutive strobes, ready high
    for (int i = 0; i < 3; i++) rnd_strobe(1'b1, 1'b0);
    idle(1'b1, 32);
    drain();

    // Reset mid-record, with more records queued behind it
    for (int i = 0; i < 3; i++) rnd_strobe(1'b1, 1'b0);
    idle(1'b1, 5);
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);
    rnd_strobe(1'b1, 1'b0);
    drain();

    // Randomized traffic in segments with different ready/strobe densities
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 500; i++) begin
        bit stb, rdy, clr, rst_n;
        stb   = $urandom_range(0, 99) < (20 + seg * 8);
        rdy   = $urandom_range(0, 99) < (90 - seg * 12);
        clr   = $urandom_range(0, 99) == 0;
        rst_n = $urandom_range(0, 999) != 0;
        cyc(stb, 4'($urandom), $urandom, $urandom, 4'($urandom), rdy, clr, rst_n);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
